// File: rtl/efuse_macro_emu.sv
// Emulator of the 256-bit eFuse hard macro: stores fuse state, blows bits on
// valid program strobes, returns bytes on valid read strobes, and flags the
// first strobe protocol or timing violation.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no mode selected, waiting for pgmen or rden
// PGM_SETUP   | pgmen held, waiting for aen
// PGM_STROBE  | program strobe active, counting its width
// RD_SETUP    | rden held, waiting for aen
// RD_STROBE   | read strobe active, counting its width
// ABORT       | after an error, waiting for pgmen, rden and aen all low
//
// Error codes: 1 both modes, 2 strobe too short, 3 overburn, 4 addr change,
// 5 mode dropped mid-strobe, 6 stray strobe, 7 strobe with mode rising.
module efuse_macro_emu #(
    parameter int TPGM_MIN = 4,
    parameter int TPGM_MAX = 16,
    parameter int TRD_MIN  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       efuse_pgmen_i,
    input  logic       efuse_rden_i,
    input  logic       efuse_aen_i,
    input  logic [7:0] efuse_addr_i,
    output logic [7:0] efuse_rdata_o,
    output logic       pgm_done_o,
    output logic       rd_done_o,
    output logic       prot_err_o,
    output logic [2:0] err_code_o,
    input  logic       err_clr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PGM_SETUP,
        S_PGM_STROBE,
        S_RD_SETUP,
        S_RD_STROBE,
        S_ABORT
    } state_t;

    localparam logic [7:0] PGM_MIN_W = 8'(TPGM_MIN);
    localparam logic [7:0] PGM_MAX_W = 8'(TPGM_MAX);
    localparam logic [7:0] RD_MIN_W  = 8'(TRD_MIN);

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [31:0][7:0] fuse_q, fuse_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             pgm_done_q, pgm_done_d;
    logic             rd_done_q, rd_done_d;
    logic             prot_err_q, prot_err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [2:0]       err_new;
    logic [7:0]       wcnt_inc;

    assign wcnt_inc = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;

    // Next-state, width counting, array/rdata updates and error detection.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        fuse_d     = fuse_q;
        rdata_d    = rdata_q;
        pgm_done_d = 1'b0;
        rd_done_d  = 1'b0;
        err_new    = 3'd0;

        if (efuse_pgmen_i && efuse_rden_i) begin
            err_new = 3'd1;
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (efuse_aen_i) begin
                        err_new = (efuse_pgmen_i || efuse_rden_i) ? 3'd7 : 3'd6;
                        state_d = S_ABORT;
                    end else if (efuse_pgmen_i) begin
                        state_d = S_PGM_SETUP;
                    end else if (efuse_rden_i) begin
                        state_d = S_RD_SETUP;
                    end
                end
                S_PGM_SETUP: begin
                    if (!efuse_pgmen_i) begin
                        // Own mode gone: a strobe now is a setup/stray error.
                        if (efuse_aen_i) begin
                            err_new = efuse_rden_i ? 3'd7 : 3'd6;
                            state_d = S_ABORT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (efuse_aen_i) begin
                        wcnt_d  = 8'd1;
                        addr_d  = efuse_addr_i;
                        state_d = S_PGM_STROBE;
                    end
                end
                S_RD_SETUP: begin
                    if (!efuse_rden_i) begin
                        if (efuse_aen_i) begin
                            err_new = efuse_pgmen_i ? 3'd7 : 3'd6;
                            state_d = S_ABORT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (efuse_aen_i) begin
                        wcnt_d  = 8'd1;
                        addr_d  = efuse_addr_i;
                        state_d = S_RD_STROBE;
                    end
                end
                S_PGM_STROBE: begin
                    if (efuse_aen_i) begin
                        if (!efuse_pgmen_i) begin
                            err_new = 3'd5;
                            state_d = S_ABORT;
                        end else if (efuse_addr_i != addr_q) begin
                            err_new = 3'd4;
                            state_d = S_ABORT;
                        end else begin
                            wcnt_d = wcnt_inc;
                        end
                    end else begin
                        if (wcnt_q < PGM_MIN_W) begin
                            err_new = 3'd2;
                        end else if (wcnt_q > PGM_MAX_W) begin
                            err_new = 3'd3;
                        end else begin
                            fuse_d[addr_q[7:3]][addr_q[2:0]] = 1'b1;
                            pgm_done_d = 1'b1;
                        end
                        state_d = S_PGM_SETUP;
                    end
                end
                S_RD_STROBE: begin
                    if (efuse_aen_i) begin
                        if (!efuse_rden_i) begin
                            err_new = 3'd5;
                            state_d = S_ABORT;
                        end else if (efuse_addr_i != addr_q) begin
                            err_new = 3'd4;
                            state_d = S_ABORT;
                        end else begin
                            wcnt_d = wcnt_inc;
                        end
                    end else begin
                        if (wcnt_q < RD_MIN_W) begin
                            err_new = 3'd2;
                        end else begin
                            rdata_d   = fuse_q[addr_q[7:3]];
                            rd_done_d = 1'b1;
                        end
                        state_d = S_RD_SETUP;
                    end
                end
                S_ABORT: begin
                    if (!efuse_pgmen_i && !efuse_rden_i && !efuse_aen_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sticky error flag and first-error code; a new error beats a clear.
    always_comb begin
        prot_err_d = err_clr_i ? 1'b0 : prot_err_q;
        if (err_new != 3'd0) begin
            prot_err_d = 1'b1;
        end
        err_code_d = err_code_q;
        if (err_clr_i || (err_code_q == 3'd0)) begin
            err_code_d = err_new;
        end
    end

    // State, array and output registers; reset emulates a fresh part.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 8'd0;
            addr_q     <= 8'd0;
            fuse_q     <= '0;
            rdata_q    <= 8'd0;
            pgm_done_q <= 1'b0;
            rd_done_q  <= 1'b0;
            prot_err_q <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            fuse_q     <= fuse_d;
            rdata_q    <= rdata_d;
            pgm_done_q <= pgm_done_d;
            rd_done_q  <= rd_done_d;
            prot_err_q <= prot_err_d;
            err_code_q <= err_code_d;
        end
    end

    assign efuse_rdata_o = rdata_q;
    assign pgm_done_o    = pgm_done_q;
    assign rd_done_o     = rd_done_q;
    assign prot_err_o    = prot_err_q;
    assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_efuse_macro_emu.sv
// Directed bench for efuse_macro_emu: program/read flows, width limits,
// protocol errors, error capture/clear and mid-strobe reset.
module tb_efuse_macro_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       efuse_pgmen_i;
    logic       efuse_rden_i;
    logic       efuse_aen_i;
    logic [7:0] efuse_addr_i;
    logic [7:0] efuse_rdata_o;
    logic       pgm_done_o;
    logic       rd_done_o;
    logic       prot_err_o;
    logic [2:0] err_code_o;
    logic       err_clr_i;

    int n_chk  = 0;
    int n_pass = 0;

    efuse_macro_emu #(.TPGM_MIN(4), .TPGM_MAX(16), .TRD_MIN(2)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .efuse_pgmen_i (efuse_pgmen_i),
        .efuse_rden_i  (efuse_rden_i),
        .efuse_aen_i   (efuse_aen_i),
        .efuse_addr_i  (efuse_addr_i),
        .efuse_rdata_o (efuse_rdata_o),
        .pgm_done_o    (pgm_done_o),
        .rd_done_o     (rd_done_o),
        .prot_err_o    (prot_err_o),
        .err_code_o    (err_code_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp_v);
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] a, input int w);
        efuse_aen_i  = 1'b1;
        efuse_addr_i = a;
        step(w);
        efuse_aen_i  = 1'b0;
        step(1);
    endtask

    task automatic clr_err();
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
    endtask

    task automatic pgm_op(input string tag, input logic [7:0] a, input int w, input logic exp_done);
        efuse_pgmen_i = 1'b1;
        step(1);
        strobe(a, w);
        chk({tag, "_done"}, {7'd0, pgm_done_o}, {7'd0, exp_done});
        efuse_pgmen_i = 1'b0;
        step(1);
        chk({tag, "_done_end"}, {7'd0, pgm_done_o}, 8'd0);
    endtask

    task automatic rd_op(input string tag, input logic [7:0] a, input int w,
                         input logic exp_done, input logic [7:0] exp_data);
        efuse_rden_i = 1'b1;
        step(1);
        strobe(a, w);
        chk({tag, "_done"}, {7'd0, rd_done_o}, {7'd0, exp_done});
        chk({tag, "_data"}, efuse_rdata_o, exp_data);
        efuse_rden_i = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n         = 1'b0;
        efuse_pgmen_i = 1'b0;
        efuse_rden_i  = 1'b0;
        efuse_aen_i   = 1'b0;
        efuse_addr_i  = 8'h00;
        err_clr_i     = 1'b0;
        step(2);
        chk("rst_rdata", efuse_rdata_o, 8'h00);
        chk("rst_err_code", {5'd0, err_code_o}, 8'd0);
        chk("rst_prot_err", {7'd0, prot_err_o}, 8'd0);
        chk("rst_pgm_done", {7'd0, pgm_done_o}, 8'd0);
        chk("rst_rd_done", {7'd0, rd_done_o}, 8'd0);
        rst_n = 1'b1;
        step(1);

        // Basic program then read back of byte 1.
        pgm_op("pgm_0b", 8'h0B, 8, 1'b1);
        rd_op("rd_08", 8'h08, 2, 1'b1, 8'h08);
        chk("basic_prot_err", {7'd0, prot_err_o}, 8'd0);

        // Strobe width limits on programming.
        pgm_op("pgm_short", 8'h00, 3, 1'b0);
        chk("short_code", {5'd0, err_code_o}, 8'd2);
        chk("short_prot", {7'd0, prot_err_o}, 8'd1);
        rd_op("rd_after_short", 8'h00, 2, 1'b1, 8'h00);
        clr_err();
        chk("clr1_code", {5'd0, err_code_o}, 8'd0);
        pgm_op("pgm_long", 8'h00, 17, 1'b0);
        chk("long_code", {5'd0, err_code_o}, 8'd3);
        rd_op("rd_after_long", 8'h00, 2, 1'b1, 8'h00);
        clr_err();

        // Both modes high, then ABORT must ignore aen until all inputs drop.
        efuse_pgmen_i = 1'b1;
        efuse_rden_i  = 1'b1;
        step(1);
        chk("both_code", {5'd0, err_code_o}, 8'd1);
        efuse_pgmen_i = 1'b0;
        efuse_rden_i  = 1'b0;
        efuse_aen_i   = 1'b1;
        err_clr_i     = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        chk("abort_clr_code", {5'd0, err_code_o}, 8'd0);
        step(1);
        chk("abort_hold_code", {5'd0, err_code_o}, 8'd0);
        chk("abort_hold_prot", {7'd0, prot_err_o}, 8'd0);
        efuse_aen_i = 1'b0;
        step(1);
        rd_op("rd_after_abort", 8'h08, 2, 1'b1, 8'h08);

        // Address change mid-read, then first-error-wins and clear.
        efuse_rden_i = 1'b1;
        step(1);
        efuse_aen_i  = 1'b1;
        efuse_addr_i = 8'h10;
        step(1);
        efuse_addr_i = 8'h18;
        step(1);
        chk("addr_chg_code", {5'd0, err_code_o}, 8'd4);
        chk("addr_chg_rdata", efuse_rdata_o, 8'h08);
        chk("addr_chg_rd_done", {7'd0, rd_done_o}, 8'd0);
        efuse_rden_i = 1'b0;
        efuse_aen_i  = 1'b0;
        step(1);
        efuse_aen_i = 1'b1;
        step(1);
        chk("stray_keeps_code", {5'd0, err_code_o}, 8'd4);
        chk("stray_prot", {7'd0, prot_err_o}, 8'd1);
        efuse_aen_i = 1'b0;
        step(1);
        clr_err();
        chk("clr2_code", {5'd0, err_code_o}, 8'd0);
        chk("clr2_prot", {7'd0, prot_err_o}, 8'd0);
        efuse_aen_i = 1'b1;
        err_clr_i   = 1'b1;
        step(1);
        chk("clr_vs_new_code", {5'd0, err_code_o}, 8'd6);
        chk("clr_vs_new_prot", {7'd0, prot_err_o}, 8'd1);
        efuse_aen_i = 1'b0;
        err_clr_i   = 1'b0;
        step(1);
        clr_err();
        rd_op("rd_short", 8'h00, 1, 1'b0, 8'h08);
        chk("rd_short_code", {5'd0, err_code_o}, 8'd2);
        clr_err();

        // Back-to-back blows under one pgmen, then reprogram an existing bit.
        efuse_pgmen_i = 1'b1;
        step(1);
        strobe(8'h00, 4);
        chk("b2b_first_done", {7'd0, pgm_done_o}, 8'd1);
        strobe(8'h07, 5);
        chk("b2b_second_done", {7'd0, pgm_done_o}, 8'd1);
        efuse_pgmen_i = 1'b0;
        step(1);
        rd_op("rd_81", 8'h00, 2, 1'b1, 8'h81);
        pgm_op("reprog_00", 8'h00, 16, 1'b1);
        rd_op("rd_81_again", 8'h03, 2, 1'b1, 8'h81);
        chk("reprog_code", {5'd0, err_code_o}, 8'd0);

        // Reset in the 5th cycle of a 6-cycle program strobe.
        efuse_pgmen_i = 1'b1;
        step(1);
        efuse_aen_i  = 1'b1;
        efuse_addr_i = 8'h10;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", efuse_rdata_o, 8'h00);
        chk("midrst_pgm_done", {7'd0, pgm_done_o}, 8'd0);
        chk("midrst_prot", {7'd0, prot_err_o}, 8'd0);
        efuse_pgmen_i = 1'b0;
        efuse_aen_i   = 1'b0;
        efuse_addr_i  = 8'h00;
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("post_rst_no_done", {7'd0, pgm_done_o}, 8'd0);
        end
        rd_op("rd_after_rst_b2", 8'h10, 2, 1'b1, 8'h00);
        rd_op("rd_after_rst_b0", 8'h00, 2, 1'b1, 8'h00);
        chk("post_rst_code", {5'd0, err_code_o}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/efuse_macro_emu.md
# efuse_macro_emu

Cycle-accurate synthesizable emulator of the 256-bit eFuse macro, acting as the responder on the pgmen/rden/aen/addr/rdata macro interface driven by the eFuse controller mux. It stores fuse state, blows bits on valid program strobes, and returns bytes on valid read strobes. It also checks strobe protocol and timing and reports the first violation. It replaces the hard macro in FPGA prototypes and in controller-level simulation.

## Interface
- TPGM_MIN, default 4: minimum program strobe width (aen high), in clk cycles.
- TPGM_MAX, default 16: maximum program strobe width; longer strobes are overburn errors.
- TRD_MIN, default 2: minimum read strobe width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- efuse_pgmen_i  in  1  program mode enable.
- efuse_rden_i  in  1  read mode enable.
- efuse_aen_i  in  1  access strobe.
- efuse_addr_i  in  8  program: bit index {byte[4:0],bit[2:0]}; read: byte index = addr[7:3], addr[2:0] ignored.
- efuse_rdata_o  out  8  last read byte, held until the next valid read.
- pgm_done_o  out  1  one-cycle pulse after a fuse bit is blown.
- rd_done_o  out  1  one-cycle pulse after rdata_o is updated.
- prot_err_o  out  1  sticky protocol error flag.
- err_code_o  out  3  code of the first captured error; 0 when there is no error.
- err_clr_i  in  1  clears prot_err_o and err_code_o.

## Operation
- Fuse array: 32x8 bits, reset to all 0 by rst_n (emulates a fresh part). Bits only go 0->1; programming an already-blown bit is legal and leaves it 1.
- FSM states: IDLE, PGM_SETUP, PGM_STROBE, RD_SETUP, RD_STROBE, ABORT.
- IDLE
  - pgmen=1, rden=0, aen=0 -> PGM_SETUP.
  - rden=1, pgmen=0, aen=0 -> RD_SETUP.
  - aen=1 with pgmen or rden rising in the same cycle -> err 7 (setup), ABORT.
  - aen=1 with both modes low -> err 6 (stray strobe), ABORT.
- SETUP states
  - aen=1 -> STROBE. Width counter wcnt loads 1; addr is latched into addr_q.
  - Mode input dropping with aen=0 -> IDLE, no error.
- STROBE states
  - While aen=1: wcnt increments, saturating at 255.
  - aen falls: check width.
    - PGM: wcnt in [TPGM_MIN, TPGM_MAX] blows fuse[addr_q]. wcnt < TPGM_MIN -> err 2. wcnt > TPGM_MAX -> err 3; no blow on either error.
    - RD: wcnt >= TRD_MIN loads rdata_o with byte[addr_q[7:3]]. Shorter -> err 2; rdata_o is unchanged.
    - Then return to the SETUP state of the same mode, so back-to-back strobes need no mode toggling.
  - While aen=1: addr != addr_q -> err 4. Mode input drops -> err 5. Either error -> ABORT with no array or rdata update.
- pgmen=1 and rden=1 together in any state -> err 1, ABORT. This has priority over all other checks.
- ABORT: waits until pgmen=rden=aen=0, then goes to IDLE.
- Error capture
  - prot_err_o sets on any error.
  - err_code_o latches only when it is currently 0 (first error wins).
  - err_clr_i clears both. If a new error occurs in the same cycle as err_clr_i, the new error wins.

## Timing
- All inputs are sampled at posedge clk; the inputs are already registered by the driver.
- Strobe width = number of consecutive cycles aen is sampled high.
- The fuse blow or rdata_o update occurs at the edge where aen is first sampled low.
- pgm_done_o / rd_done_o are high in the cycle after that edge: one cycle total latency from aen falling.
- Read data reflects blows completed at earlier edges. A read strobe that starts the cycle after pgm_done_o sees the new bit.
- Reset values: efuse_rdata_o=0x00, pgm_done_o=0, rd_done_o=0, prot_err_o=0, err_code_o=0, FSM=IDLE, array all 0.
- rst_n asserted mid-strobe aborts immediately. The array clears, there is no partial blow, and no done pulse is generated.

## Test plan
- Program bit 0x0B with pgmen setup 1 cycle and aen high 8 cycles -> pgm_done_o pulses 1 cycle after aen falls. Then read addr 0x08 with aen 2 cycles -> rdata_o=0x08, rd_done_o pulses, prot_err_o=0.
- Program strobe of 3 cycles -> err_code_o=2, no blow (a following read of byte 0 returns 0x00). Program strobe of 17 cycles -> err 3 stays captured as the first error? No: after err_clr_i, the 17-cycle strobe gives err_code_o=3, no blow.
- pgmen and rden both high -> err_code_o=1, FSM goes to ABORT. It returns to IDLE only after all of pgmen, rden and aen are 0; a subsequent valid read succeeds.
- Read strobe with addr changing from 0x10 to 0x18 mid-strobe -> err_code_o=4, rdata_o holds its old value. A second error (stray aen) leaves err_code_o=4. err_clr_i -> err_code_o=0.
- Blow bits 0x00 and 0x07 back-to-back under a single pgmen high, then read byte 0 -> 0x81. Reprogramming bit 0x00 -> still 0x81, no error.
- rst_n asserted during the 5th cycle of a 6-cycle program strobe -> all outputs reset to 0, pgm_done_o never pulses, and a read of that byte after reset returns 0x00.
